// File: rtl/cp0_state_regs.sv
// -----------------------------------------------------------------------------
// cp0_state_regs
//
// Purpose:
//   CP0 register file. Holds Status, Cause, EPC, BadVAddr, Count/Compare,
//   EntryHi (ASID only), EBase and a constant PRId. It serves MTC0 writes and
//   MFC0 reads, and applies exception and ERET commits from the exception
//   unit. It feeds interrupt and vectoring controls back to that unit.
//
// Parameters:
//   PRID_VALUE  constant returned for PRId (reg 15, sel 0)
//   COUNT_DIV   Count advances once every 2**COUNT_DIV clocks (0 = every clock)
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   hw_int[5:0]              level-sensitive external interrupts -> Cause.IP[7:2]
//   cp0_wen/waddr/wsel/wdata MTC0 write port
//   cp0_raddr/rsel, cp0_rdata MFC0 read port (combinational, pre-edge state)
//   cp0_exp_*                exception commit (EPC, ExcCode, BD, BadVAddr, ASID)
//   cp0_exl_clean            ERET commit, clears Status.EXL
//   epc_address, cp0_ebase   EPC and EBase registers
//   allow_interrupt          Status.IE & ~Status.EXL
//   interrupt_flag[7:0]      Cause.IP & Status.IM
//   cp0_use_special_iv       Cause.IV
//   cp0_use_bootstrap_iv     Status.BEV
//   exl_set, asid, timer_int Status.EXL, EntryHi.ASID, Cause.TI
// -----------------------------------------------------------------------------
module cp0_state_regs #(
    parameter logic [31:0] PRID_VALUE = 32'h0001_8000,
    parameter int unsigned COUNT_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  hw_int,
    input  logic        cp0_wen,
    input  logic [4:0]  cp0_waddr,
    input  logic [2:0]  cp0_wsel,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    input  logic [2:0]  cp0_rsel,
    output logic [31:0] cp0_rdata,
    input  logic        cp0_exp_en,
    input  logic        cp0_exl_clean,
    input  logic [31:0] cp0_exp_epc,
    input  logic [4:0]  cp0_exp_code,
    input  logic [31:0] cp0_exp_bad_vaddr,
    input  logic        cp0_exp_bad_vaddr_wen,
    input  logic        cp0_exp_bd,
    input  logic [7:0]  cp0_exp_asid,
    input  logic        cp0_exp_asid_en,
    output logic [31:0] epc_address,
    output logic        allow_interrupt,
    output logic [7:0]  interrupt_flag,
    output logic [31:0] cp0_ebase,
    output logic        cp0_use_special_iv,
    output logic        cp0_use_bootstrap_iv,
    output logic        exl_set,
    output logic [7:0]  asid,
    output logic        timer_int
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_ENTRYHI  = 5'd10;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    // Prescaler is at least one bit wide so the declaration stays legal
    // when COUNT_DIV is 0; in that case it is simply ignored.
    localparam int PW = (COUNT_DIV > 0) ? int'(COUNT_DIV) : 1;

    // Status fields
    logic        sr_bev_q, sr_bev_d;
    logic [7:0]  sr_im_q,  sr_im_d;
    logic        sr_exl_q, sr_exl_d;
    logic        sr_ie_q,  sr_ie_d;
    // Cause fields
    logic        ca_bd_q,  ca_bd_d;
    logic        ca_ti_q,  ca_ti_d;
    logic        ca_iv_q,  ca_iv_d;
    logic [7:0]  ca_ip_q,  ca_ip_d;
    logic [4:0]  ca_exc_q, ca_exc_d;
    // Full-width and partial registers
    logic [31:0] epc_q,      epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q,    count_d;
    logic [31:0] compare_q,  compare_d;
    logic [7:0]  asid_q,     asid_d;
    logic [17:0] ebase_q,    ebase_d;   // EBase[29:12]
    logic [PW-1:0] presc_q,  presc_d;

    logic count_tick;

    generate
        if (COUNT_DIV == 0) begin : g_nodiv
            assign count_tick = 1'b1;
        end else begin : g_div
            assign count_tick = &presc_q;
        end
    endgenerate

    // MTC0 write decode
    logic wr_status, wr_cause, wr_epc, wr_count, wr_compare, wr_entryhi, wr_ebase;

    always_comb begin
        wr_status  = cp0_wen && (cp0_waddr == REG_STATUS)  && (cp0_wsel == 3'd0);
        wr_cause   = cp0_wen && (cp0_waddr == REG_CAUSE)   && (cp0_wsel == 3'd0);
        wr_epc     = cp0_wen && (cp0_waddr == REG_EPC)     && (cp0_wsel == 3'd0);
        wr_count   = cp0_wen && (cp0_waddr == REG_COUNT)   && (cp0_wsel == 3'd0);
        wr_compare = cp0_wen && (cp0_waddr == REG_COMPARE) && (cp0_wsel == 3'd0);
        wr_entryhi = cp0_wen && (cp0_waddr == REG_ENTRYHI) && (cp0_wsel == 3'd0);
        wr_ebase   = cp0_wen && (cp0_waddr == REG_PRID)    && (cp0_wsel == 3'd1);
    end

    // Next-state logic. Sources are applied lowest priority first (MTC0,
    // then ERET, then exception) so a higher source overrides exactly the
    // fields it touches and leaves the rest to the lower ones.
    always_comb begin
        sr_bev_d   = sr_bev_q;
        sr_im_d    = sr_im_q;
        sr_exl_d   = sr_exl_q;
        sr_ie_d    = sr_ie_q;
        ca_bd_d    = ca_bd_q;
        ca_ti_d    = ca_ti_q;
        ca_iv_d    = ca_iv_q;
        ca_ip_d    = ca_ip_q;
        ca_exc_d   = ca_exc_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        asid_d     = asid_q;
        ebase_d    = ebase_q;
        presc_d    = presc_q;

        // MTC0
        if (wr_status) begin
            sr_bev_d = cp0_wdata[22];
            sr_im_d  = cp0_wdata[15:8];
            sr_exl_d = cp0_wdata[1];
            sr_ie_d  = cp0_wdata[0];
        end
        if (wr_cause) begin
            ca_iv_d      = cp0_wdata[23];
            ca_ip_d[1:0] = cp0_wdata[9:8];
        end
        if (wr_epc)     epc_d     = cp0_wdata;
        if (wr_compare) compare_d = cp0_wdata;
        if (wr_entryhi) asid_d    = cp0_wdata[7:0];
        if (wr_ebase)   ebase_d   = cp0_wdata[29:12];

        // Hardware interrupt pending bits; the timer shares line 5.
        ca_ip_d[7:2] = {hw_int[5] | ca_ti_q, hw_int[4:0]};

        // Count / prescaler; a Count write beats a same-cycle tick.
        if (wr_count) begin
            count_d = cp0_wdata;
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
            if (count_tick) begin
                count_d = count_q + 32'd1;
            end
        end

        // Timer interrupt: sticky until Compare is rewritten.
        if (wr_compare) begin
            ca_ti_d = 1'b0;
        end else if (count_q == compare_q) begin
            ca_ti_d = 1'b1;
        end

        // ERET
        if (cp0_exl_clean) begin
            sr_exl_d = 1'b0;
        end

        // Exception commit. EPC/BD are only captured for a non-nested
        // exception so the original return address survives.
        if (cp0_exp_en) begin
            ca_exc_d = cp0_exp_code;
            sr_exl_d = 1'b1;
            if (!sr_exl_q) begin
                epc_d   = cp0_exp_epc;
                ca_bd_d = cp0_exp_bd;
            end
            if (cp0_exp_bad_vaddr_wen) badvaddr_d = cp0_exp_bad_vaddr;
            if (cp0_exp_asid_en)       asid_d     = cp0_exp_asid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_bev_q   <= 1'b1;
            sr_im_q    <= 8'h00;
            sr_exl_q   <= 1'b0;
            sr_ie_q    <= 1'b0;
            ca_bd_q    <= 1'b0;
            ca_ti_q    <= 1'b0;
            ca_iv_q    <= 1'b0;
            ca_ip_q    <= 8'h00;
            ca_exc_q   <= 5'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
            asid_q     <= 8'h00;
            ebase_q    <= 18'd0;
            presc_q    <= '0;
        end else begin
            sr_bev_q   <= sr_bev_d;
            sr_im_q    <= sr_im_d;
            sr_exl_q   <= sr_exl_d;
            sr_ie_q    <= sr_ie_d;
            ca_bd_q    <= ca_bd_d;
            ca_ti_q    <= ca_ti_d;
            ca_iv_q    <= ca_iv_d;
            ca_ip_q    <= ca_ip_d;
            ca_exc_q   <= ca_exc_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            asid_q     <= asid_d;
            ebase_q    <= ebase_d;
            presc_q    <= presc_d;
        end
    end

    // MFC0: plain read of current register state, no write bypass.
    always_comb begin
        cp0_rdata = 32'd0;
        if (cp0_rsel == 3'd0) begin
            case (cp0_raddr)
                REG_BADVADDR: cp0_rdata = badvaddr_q;
                REG_COUNT:    cp0_rdata = count_q;
                REG_ENTRYHI:  cp0_rdata = {24'd0, asid_q};
                REG_COMPARE:  cp0_rdata = compare_q;
                REG_STATUS:   cp0_rdata = {9'd0, sr_bev_q, 6'd0, sr_im_q, 6'd0, sr_exl_q, sr_ie_q};
                REG_CAUSE:    cp0_rdata = {ca_bd_q, ca_ti_q, 6'd0, ca_iv_q, 7'd0, ca_ip_q,
                                           1'b0, ca_exc_q, 2'd0};
                REG_EPC:      cp0_rdata = epc_q;
                REG_PRID:     cp0_rdata = PRID_VALUE;
                default:      cp0_rdata = 32'd0;
            endcase
        end else if ((cp0_rsel == 3'd1) && (cp0_raddr == REG_PRID)) begin
            cp0_rdata = {2'b10, ebase_q, 12'd0};
        end
    end

    assign epc_address          = epc_q;
    assign allow_interrupt      = sr_ie_q & ~sr_exl_q;
    assign interrupt_flag       = ca_ip_q & sr_im_q;
    assign cp0_ebase            = {2'b10, ebase_q, 12'd0};
    assign cp0_use_special_iv   = ca_iv_q;
    assign cp0_use_bootstrap_iv = sr_bev_q;
    assign exl_set              = sr_exl_q;
    assign asid                 = asid_q;
    assign timer_int            = ca_ti_q;

endmodule
